// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle for the sequential ALU.
//   start, a, b, mode           : request from the front end (master drives)
//   ready, valid, result,
//   carry, zero, err            : status and registered result (slave drives)
// W is the operand width; result is 2*W bits wide.
interface seq_alu_if #(
  parameter int W = 6
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [3:0]     mode;
  logic           ready;
  logic           valid;
  logic [2*W-1:0] result;
  logic           carry;
  logic           zero;
  logic           err;

  modport master (
    output start, a, b, mode,
    input  ready, valid, result, carry, zero, err
  );

  modport slave (
    input  start, a, b, mode,
    output ready, valid, result, carry, zero, err
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with an accumulator and an optional iterative
// shift-add multiplier.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : seq_alu_if.slave (start/a/b/mode in; ready/valid/result/
//           carry/zero/err out, all outputs registered)
// Build option: define SEQ_ALU_MULT_EN to include the multiplier (mode D
// then takes W cycles). Without it mode D completes in one cycle with err=1.
module seq_alu #(
  parameter int W = 6
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);
  localparam int W2 = 2 * W;

  localparam logic [3:0] M_ADD    = 4'h0;
  localparam logic [3:0] M_SUB    = 4'h1;
  localparam logic [3:0] M_BSUBA  = 4'h2;
  localparam logic [3:0] M_INC    = 4'h3;
  localparam logic [3:0] M_DEC    = 4'h4;
  localparam logic [3:0] M_NEGA   = 4'h5;
  localparam logic [3:0] M_NEGB   = 4'h6;
  localparam logic [3:0] M_NOTA   = 4'h7;
  localparam logic [3:0] M_NOTB   = 4'h8;
  localparam logic [3:0] M_NOR    = 4'h9;
  localparam logic [3:0] M_XOR    = 4'hA;
  localparam logic [3:0] M_XNOR   = 4'hB;
  localparam logic [3:0] M_CMP    = 4'hC;
  localparam logic [3:0] M_MULT   = 4'hD;
  localparam logic [3:0] M_ACC    = 4'hE;
  localparam logic [3:0] M_CLRACC = 4'hF;

  localparam logic [W2-1:0] ONE_X  = {{(W2-1){1'b0}}, 1'b1};
  localparam logic [W2-1:0] CMP_GT = {{(W2-2){1'b0}}, 2'b01};
  localparam logic [W2-1:0] CMP_LT = {{(W2-2){1'b0}}, 2'b10};

`ifdef SEQ_ALU_MULT_EN
  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
`else
  typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [W2-1:0]   result_q, result_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
  logic [W2-1:0]   acc_q, acc_d;

`ifdef SEQ_ALU_MULT_EN
  logic [W2-1:0]   mcand_q, mcand_d;   // a, shifted left each iteration
  logic [W-1:0]    mplier_q, mplier_d; // b, shifted right; bit 0 is current
  logic [W2-1:0]   prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   prod_nxt_s;
`endif

  logic [W2-1:0]   a_x_s, b_x_s;
  logic [W2-1:0]   add_s;
  logic [W2:0]     acc_sum_s;          // one extra bit to catch the wrap
  logic [W2-1:0]   alu_res_s;
  logic            alu_carry_s;
  logic            alu_err_s;
  logic            take_mul_s;

  assign a_x_s     = {{W{1'b0}}, bus.a};
  assign b_x_s     = {{W{1'b0}}, bus.b};
  assign add_s     = a_x_s + b_x_s;
  assign acc_sum_s = {1'b0, acc_q} + {1'b0, a_x_s};

`ifdef SEQ_ALU_MULT_EN
  assign take_mul_s = bus.start && (bus.mode == M_MULT);
`else
  assign take_mul_s = 1'b0;
`endif

  // Single-cycle datapath: result, carry/borrow and err for the current mode.
  always_comb begin
    alu_res_s   = '0;
    alu_carry_s = 1'b0;
    alu_err_s   = 1'b0;
    case (bus.mode)
      M_ADD:    begin alu_res_s = add_s;          alu_carry_s = add_s[W];        end
      M_SUB:    begin alu_res_s = a_x_s - b_x_s;  alu_carry_s = (bus.a < bus.b); end
      M_BSUBA:  begin alu_res_s = b_x_s - a_x_s;  alu_carry_s = (bus.b < bus.a); end
      M_INC:    alu_res_s = a_x_s + ONE_X;
      M_DEC:    begin alu_res_s = a_x_s - ONE_X;  alu_carry_s = (bus.a == '0);   end
      M_NEGA:   alu_res_s = ~a_x_s + ONE_X;
      M_NEGB:   alu_res_s = ~b_x_s + ONE_X;
      M_NOTA:   alu_res_s = {{W{1'b0}}, ~bus.a};
      M_NOTB:   alu_res_s = {{W{1'b0}}, ~bus.b};
      M_NOR:    alu_res_s = {{W{1'b0}}, ~(bus.a | bus.b)};
      M_XOR:    alu_res_s = {{W{1'b0}}, bus.a ^ bus.b};
      M_XNOR:   alu_res_s = {{W{1'b0}}, ~(bus.a ^ bus.b)};
      M_CMP: begin
        if (bus.a > bus.b) begin
          alu_res_s = CMP_GT;
        end else if (bus.a < bus.b) begin
          alu_res_s = CMP_LT;
        end else begin
          alu_res_s = '0;
        end
      end
`ifdef SEQ_ALU_MULT_EN
      M_MULT:   alu_res_s = '0;  // handled by the MUL state
`else
      M_MULT:   alu_err_s = 1'b1;
`endif
      M_ACC:    begin alu_res_s = acc_sum_s[W2-1:0]; alu_carry_s = acc_sum_s[W2]; end
      M_CLRACC: alu_res_s = '0;
      default:  alu_res_s = '0;
    endcase
  end

  // FSM next state, accumulator update and multiplier iteration.
  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    acc_d    = acc_q;
`ifdef SEQ_ALU_MULT_EN
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    prod_nxt_s = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (take_mul_s) begin
`ifdef SEQ_ALU_MULT_EN
          state_d  = MUL;
          mcand_d  = a_x_s;
          mplier_d = bus.b;
          prod_d   = '0;
          cnt_d    = '0;
`endif
        end else if (bus.start) begin
          valid_d  = 1'b1;
          result_d = alu_res_s;
          carry_d  = alu_carry_s;
          zero_d   = (alu_res_s == '0);
          err_d    = alu_err_s;
          if (bus.mode == M_ACC) begin
            acc_d = acc_sum_s[W2-1:0];
          end else if (bus.mode == M_CLRACC) begin
            acc_d = '0;
          end else begin
            acc_d = acc_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
`ifdef SEQ_ALU_MULT_EN
      MUL: begin
        // Requests arriving here are dropped: ready is low.
        prod_d   = prod_nxt_s;
        mcand_d  = {mcand_q[W2-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[W-1:1]};
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          result_d = prod_nxt_s;
          carry_d  = 1'b0;
          zero_d   = (prod_nxt_s == '0);
          err_d    = 1'b0;
        end else begin
          state_d = MUL;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset also aborts any multiply in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      acc_q    <= '0;
`ifdef SEQ_ALU_MULT_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
`ifdef SEQ_ALU_MULT_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.ready  = ready_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.err    = err_q;
endmodule
